vga_timing_controller: RTL and testbench

//  Generates VGA raster timing and sequences the pixel colour datapath. Produces pixel-rate

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_axis_timer.sv | 71 +++++++
 rtl/vga_timing_controller.sv | 156 +++++++++++++++
 tb/tb_vga_timing_controller.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared phase encodings, flag payload and 640x480@60 timing defaults for the VGA raster.
package vga_timing_pkg;

  // Counter width for both raster axes
  localparam int unsigned CNT_W     = 10;
  localparam int unsigned MAX_TOTAL = 1024;

  // 640x480@60 horizontal timing (pixels)
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FRONT_DEF  = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BACK_DEF   = 48;

  // 640x480@60 vertical timing (lines)
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FRONT_DEF  = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BACK_DEF   = 33;

  // Per-axis raster phase
  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  // Flags that travel through the output delay line together
  typedef struct packed {
    logic video_on;
    logic hsync;
    logic vsync;
  } vga_flags_t;

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: wrapping position counter plus its ACTIVE/FRONT/SYNC/BACK phase FSM.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned FRONT  = H_FRONT_DEF,
  parameter int unsigned SYNC   = H_SYNC_DEF,
  parameter int unsigned BACK   = H_BACK_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output phase_e           phase,
  output logic             wrap
);

  localparam int unsigned TOTAL = ACTIVE + FRONT + SYNC + BACK;

  // Count values at which each phase begins
  localparam logic [CNT_W-1:0] FRONT_AT = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_AT  = CNT_W'(ACTIVE + FRONT);
  localparam logic [CNT_W-1:0] BACK_AT  = CNT_W'(ACTIVE + FRONT + SYNC);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);

  // Reject timings that do not fit the 10-bit counter
  if (TOTAL > MAX_TOTAL) begin : g_total_check
    $error("vga_axis_timer: total period exceeds counter range");
  end

  logic [CNT_W-1:0] count_q, count_d;
  phase_e           phase_q, phase_d;

  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      phase_q <= PH_ACTIVE;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  // Next count and phase; the phase changes on the same advance that reaches its boundary
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (advance) begin
      if (count_q == LAST) begin
        count_d = '0;
        phase_d = PH_ACTIVE;
      end else begin
        count_d = count_q + 1'b1;
        unique case (phase_q)
          PH_ACTIVE: if (count_d == FRONT_AT) phase_d = PH_FRONT;
          PH_FRONT:  if (count_d == SYNC_AT)  phase_d = PH_SYNC;
          PH_SYNC:   if (count_d == BACK_AT)  phase_d = PH_BACK;
          PH_BACK:   phase_d = PH_BACK;
          default:   phase_d = PH_ACTIVE;
        endcase
      end
    end
  end

  assign count = count_q;
  assign phase = phase_q;
  // Wrap is the advance that returns the count to zero; it chains the next axis
  assign wrap  = advance && (count_q == LAST);

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster timing: pixel prescaler, h/v axis timers, tick-aligned strobes and
// a flag delay line matching the registered colour output stage.
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FRONT    = H_FRONT_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BACK     = H_BACK_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FRONT    = V_FRONT_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BACK     = V_BACK_DEF,
  parameter int unsigned CLK_DIV    = 2,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic             pixel_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync
);

  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam vga_flags_t FLAGS_IDLE = '{video_on: 1'b0, hsync: !SYNC_POL, vsync: !SYNC_POL};

  // A zero divider has no meaningful pixel rate
  if (CLK_DIV == 0) begin : g_div_check
    $error("vga_timing_controller: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             pixel_tick_q, pixel_tick_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  logic [CNT_W-1:0] h_count, v_count;
  phase_e           h_phase, v_phase;
  logic             h_wrap, v_wrap;
  logic             h_zero_next, v_zero_next;
  logic             div_last;

  vga_flags_t flags_raw, flags_out;

  // Horizontal axis steps once per pixel. A tick already on the output always
  // commits its pixel step, so dropping enable during a tick cycle loses no pixel.
  vga_axis_timer #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h_timer (
    .clock   (clock),
    .reset   (reset),
    .advance (pixel_tick_q),
    .count   (h_count),
    .phase   (h_phase),
    .wrap    (h_wrap)
  );

  // Vertical axis steps once per line
  vga_axis_timer #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v_timer (
    .clock   (clock),
    .reset   (reset),
    .advance (h_wrap),
    .count   (v_count),
    .phase   (v_phase),
    .wrap    (v_wrap)
  );

  assign div_last = (div_q == DIV_LAST);

  // Position the counters will hold after this clock, used to qualify the strobes
  assign h_zero_next = pixel_tick_q ? h_wrap : (h_count == '0);
  assign v_zero_next = h_wrap ? v_wrap : (v_count == '0);

  // Prescaler and strobe registers
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q         <= '0;
      pixel_tick_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pixel_tick_q  <= pixel_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Prescaler next state; strobes are only raised together with a tick
  always_comb begin
    div_d         = div_q;
    pixel_tick_d  = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (enable) begin
      div_d         = div_last ? '0 : div_q + 1'b1;
      pixel_tick_d  = div_last;
      line_start_d  = div_last && h_zero_next;
      frame_start_d = div_last && h_zero_next && v_zero_next;
    end
  end

  // Undelayed flags, aligned with pixel_x/pixel_y
  always_comb begin
    flags_raw          = FLAGS_IDLE;
    flags_raw.video_on = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    flags_raw.hsync    = (h_phase == PH_SYNC) ? SYNC_POL : !SYNC_POL;
    flags_raw.vsync    = (v_phase == PH_SYNC) ? SYNC_POL : !SYNC_POL;
  end

  // Flag delay line, stepped every enabled clock to match the colour register stage
  if (PIPE_DELAY == 0) begin : g_no_pipe
    assign flags_out = flags_raw;
  end else begin : g_pipe
    vga_flags_t pipe_q [PIPE_DELAY];

    // Shift register holding the last PIPE_DELAY flag samples
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= FLAGS_IDLE;
      end else if (enable) begin
        pipe_q[0] <= flags_raw;
        for (int i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign flags_out = pipe_q[PIPE_DELAY-1];
  end

  assign pixel_tick  = pixel_tick_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign pixel_x     = h_count;
  assign pixel_y     = v_count;
  assign video_on    = flags_out.video_on;
  assign hsync       = flags_out.hsync;
  assign vsync       = flags_out.vsync;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench: full 640x480 line timing on a default instance, frame/freeze/reset
// behaviour and delay-line shifts on small-raster instances (8/2/3/2 x 4/1/2/1).
module tb_vga_timing_controller;

  logic clock = 1'b0;
  logic reset;
  logic enable;

  always #5 clock = ~clock;

  // Default 640x480 instance
  logic       d_tick, d_line, d_frame, d_video_on, d_hsync, d_vsync;
  logic [9:0] d_x, d_y;
  // Small-raster instances with PIPE_DELAY 1, 0 and 3
  logic       s1_tick, s1_line, s1_frame, s1_video_on, s1_hsync, s1_vsync;
  logic [9:0] s1_x, s1_y;
  logic       s0_tick, s0_line, s0_frame, s0_video_on, s0_hsync, s0_vsync;
  logic [9:0] s0_x, s0_y;
  logic       s3_tick, s3_line, s3_frame, s3_video_on, s3_hsync, s3_vsync;
  logic [9:0] s3_x, s3_y;

  vga_timing_controller u_def (
    .clock(clock), .reset(reset), .enable(enable),
    .pixel_tick(d_tick), .pixel_x(d_x), .pixel_y(d_y),
    .line_start(d_line), .frame_start(d_frame),
    .video_on(d_video_on), .hsync(d_hsync), .vsync(d_vsync)
  );

  vga_timing_controller #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(2), .SYNC_POL(1'b0), .PIPE_DELAY(1)
  ) u_s1 (
    .clock(clock), .reset(reset), .enable(enable),
    .pixel_tick(s1_tick), .pixel_x(s1_x), .pixel_y(s1_y),
    .line_start(s1_line), .frame_start(s1_frame),
    .video_on(s1_video_on), .hsync(s1_hsync), .vsync(s1_vsync)
  );

  vga_timing_controller #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(2), .SYNC_POL(1'b0), .PIPE_DELAY(0)
  ) u_s0 (
    .clock(clock), .reset(reset), .enable(enable),
    .pixel_tick(s0_tick), .pixel_x(s0_x), .pixel_y(s0_y),
    .line_start(s0_line), .frame_start(s0_frame),
    .video_on(s0_video_on), .hsync(s0_hsync), .vsync(s0_vsync)
  );

  vga_timing_controller #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(2), .SYNC_POL(1'b0), .PIPE_DELAY(3)
  ) u_s3 (
    .clock(clock), .reset(reset), .enable(enable),
    .pixel_tick(s3_tick), .pixel_x(s3_x), .pixel_y(s3_y),
    .line_start(s3_line), .frame_start(s3_frame),
    .video_on(s3_video_on), .hsync(s3_hsync), .vsync(s3_vsync)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Advance to the next falling edge, where outputs are stable
  task automatic step();
    @(negedge clock);
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // Safety net against a stalled raster
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int found, n, c0, c1;
    int vo_cnt, vs_cnt, hs_cnt, vs_x, vs_y;
    int tx8, tx10, f1h, f0h, f3h, f0v, f3v, mism, bad;
    logic p1h, p0h, p3h, p0v, p3v;

    // ---- reset state ----
    reset  = 1'b1;
    enable = 1'b1;
    repeat (5) step();
    check("rst_video_on",    d_video_on, 0);
    check("rst_hsync",       d_hsync,    1);
    check("rst_vsync",       d_vsync,    1);
    check("rst_pixel_x",     d_x,        0);
    check("rst_pixel_y",     d_y,        0);
    check("rst_pixel_tick",  d_tick,     0);
    check("rst_line_start",  d_line,     0);
    check("rst_frame_start", d_frame,    0);

    // ---- first tick after release ----
    reset = 1'b0;
    step();
    check("rel1_tick",        d_tick,  0);
    check("rel1_frame_start", d_frame, 0);
    step();
    check("rel2_frame_start", d_frame, 1);
    check("rel2_line_start",  d_line,  1);
    check("rel2_pixel_x",     d_x,     0);
    c0 = cyc;
    step();
    check("rel3_frame_start", d_frame, 0);
    check("rel3_pixel_x",     d_x,     1);

    // ---- default line timing ----
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      step();
      if (d_video_on === 1'b0) found = 1;
    end
    check("video_fall_found", found, 1);
    check("video_fall_x",     d_x,   640);

    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      step();
      if (d_hsync === 1'b0) found = 1;
    end
    check("hsync_fall_found", found,  1);
    check("hsync_fall_x",     d_x,    656);
    check("hsync_fall_tick",  d_tick, 1);
    n = 0;
    while (d_hsync === 1'b0 && n < 400) begin
      step();
      n++;
    end
    check("hsync_low_clocks", n, 192);

    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      step();
      if (d_line === 1'b1) found = 1;
    end
    check("line_start_found",  found,    1);
    check("line_start_period", cyc - c0, 1600);
    check("line_start_y",      d_y,      1);

    // ---- small raster frame timing ----
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      step();
      if (s1_frame === 1'b1) found = 1;
    end
    check("frame_start_found", found, 1);
    c1 = cyc;
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      step();
      if (s1_frame === 1'b1) found = 1;
    end
    check("frame_start_found2",  found,    1);
    check("frame_start_period",  cyc - c1, 240);
    check("frame_start_xy",      {s1_y, s1_x}, 0);

    vo_cnt = 0; vs_cnt = 0; hs_cnt = 0; vs_x = -1; vs_y = -1;
    for (int i = 0; i < 240; i++) begin
      if (s1_video_on === 1'b1) vo_cnt++;
      if (s1_hsync === 1'b0) hs_cnt++;
      if (s1_vsync === 1'b0) begin
        if (vs_cnt == 0) begin
          vs_x = int'(s1_x);
          vs_y = int'(s1_y);
        end
        vs_cnt++;
      end
      step();
    end
    check("frame_video_on_clocks", vo_cnt, 64);
    check("frame_hsync_clocks",    hs_cnt, 48);
    check("frame_vsync_clocks",    vs_cnt, 60);
    check("vsync_fall_y",          vs_y,   5);
    check("vsync_fall_x",          vs_x,   0);

    // ---- delay line shift relative to pixel_x ----
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      step();
      if (s1_line === 1'b1 && s1_y === 10'd1) found = 1;
    end
    check("shift_line_found", found, 1);
    tx8 = -1; tx10 = -1; f1h = -1; f0h = -1; f3h = -1; f0v = -1; f3v = -1; mism = 0;
    p1h = s1_hsync; p0h = s0_hsync; p3h = s3_hsync; p0v = s0_video_on; p3v = s3_video_on;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (tx8  < 0 && s1_x === 10'd8)  tx8  = i;
      if (tx10 < 0 && s1_x === 10'd10) tx10 = i;
      if (f1h < 0 && p1h === 1'b1 && s1_hsync === 1'b0)    f1h = i;
      if (f0h < 0 && p0h === 1'b1 && s0_hsync === 1'b0)    f0h = i;
      if (f3h < 0 && p3h === 1'b1 && s3_hsync === 1'b0)    f3h = i;
      if (f0v < 0 && p0v === 1'b1 && s0_video_on === 1'b0) f0v = i;
      if (f3v < 0 && p3v === 1'b1 && s3_video_on === 1'b0) f3v = i;
      if (s0_x !== s1_x || s3_x !== s1_x || s0_y !== s1_y || s3_y !== s1_y ||
          s0_tick !== s1_tick || s3_tick !== s1_tick || s0_line !== s1_line ||
          s3_line !== s1_line || s0_frame !== s1_frame || s3_frame !== s1_frame ||
          s0_vsync !== 1'b1 || s3_vsync !== 1'b1) mism++;
      p1h = s1_hsync; p0h = s0_hsync; p3h = s3_hsync; p0v = s0_video_on; p3v = s3_video_on;
    end
    check("shift_x8_cycle",        tx8,  15);
    check("shift_x10_cycle",       tx10, 19);
    check("pd0_hsync_fall",        f0h,  19);
    check("pd1_hsync_fall",        f1h,  20);
    check("pd3_hsync_fall",        f3h,  22);
    check("pd0_video_fall",        f0v,  15);
    check("pd3_video_fall",        f3v,  18);
    check("undelayed_consistency", mism, 0);

    // ---- freeze right after the tick for x=5, y=2 ----
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      step();
      if (s1_tick === 1'b1 && s1_x === 10'd5 && s1_y === 10'd2) found = 1;
    end
    check("freeze_point_found", found, 1);
    step();
    enable = 1'b0;
    check("freeze_start_x", s1_x, 6);
    bad = 0;
    for (int i = 0; i < 37; i++) begin
      step();
      if (s1_x !== 10'd6 || s1_y !== 10'd2 || s1_tick !== 1'b0 || s1_line !== 1'b0 ||
          s1_video_on !== 1'b1 || s1_hsync !== 1'b1 || d_tick !== 1'b0) bad++;
    end
    check("freeze_hold_violations", bad, 0);
    enable = 1'b1;
    step();
    check("resume_tick",   s1_tick, 1);
    check("resume_x",      s1_x,    6);
    step();
    step();
    check("resume_tick2",  s1_tick, 1);
    check("resume_x2",     s1_x,    7);

    // ---- reset in the middle of the sync region ----
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      step();
      if (s1_x === 10'd11 && s1_y === 10'd5) found = 1;
    end
    check("midreset_point_found", found,    1);
    check("midreset_pre_hsync",   s1_hsync, 0);
    check("midreset_pre_vsync",   s1_vsync, 0);
    reset = 1'b1;
    step();
    check("midreset_x",        s1_x,        0);
    check("midreset_y",        s1_y,        0);
    check("midreset_hsync",    s1_hsync,    1);
    check("midreset_vsync",    s1_vsync,    1);
    check("midreset_video_on", s1_video_on, 0);
    check("midreset_tick",     s1_tick,     0);
    reset = 1'b0;
    step();
    check("midreset_rel1_frame", s1_frame, 0);
    step();
    check("midreset_rel2_frame", s1_frame, 1);
    check("midreset_rel2_x",     s1_x,     0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
